// File: rtl/led_lines_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_lines_pkg
// Description : Shared constants and state encoding for the LED line
//               scheduler (default geometry, timing and the FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package led_lines_pkg;

    // Default geometry and timing of one frame
    localparam int DATA_WIDTH   = 25;      // 24-bit colour + 1 flag bit
    localparam int NUM_LINES    = 4;
    localparam int PIX_PER_LINE = 60;      // at most 64
    localparam int FRAME_CYCLES = 833333;  // 60 Hz at 50 MHz
    localparam int LATCH_CYCLES = 15000;   // 300 us at 50 MHz

    // Frame-buffer address layout: {line[1:0], pixel[5:0]}
    localparam int LINE_IDX_W = 2;
    localparam int PIX_IDX_W  = 6;
    localparam int ADDR_W     = LINE_IDX_W + PIX_IDX_W;

    // Pixel counters need one extra bit so that a full 64-pixel line is representable
    localparam int PIX_CNT_W  = PIX_IDX_W + 1;

    // Scheduler state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/led_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : led_rr_arbiter
// Description : Combinational round-robin selector. Searches the eligible
//               mask starting at i_ptr and returns a one-hot grant for the
//               first eligible requester found (all zero if none).
// Revision    : 1.0 - initial release
// ============================================================================
module led_rr_arbiter
    import led_lines_pkg::*;
#(
    parameter int N     = NUM_LINES,
    parameter int IDX_W = LINE_IDX_W
) (
    input  logic [N-1:0]     i_elig,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant
);

    logic [IDX_W-1:0] w_idx;

    // Walk the search order backwards so the last hit written is the first in priority
    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = IDX_W'((int'(i_ptr) + k) % N);
            if (i_elig[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_line_sched.sv
`default_nettype none
// ============================================================================
// Module      : led_line_sched
// Description : Frame scheduler feeding NUM_LINES LED line serializers from a
//               shared frame buffer. A free-running frame counter requests a
//               frame; the FETCH phase serves per-line pixel requests one read
//               per cycle in round-robin order; the LATCH phase then holds all
//               latch lines high before returning to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module led_line_sched #(
    parameter int DATA_WIDTH   = led_lines_pkg::DATA_WIDTH,
    parameter int NUM_LINES    = led_lines_pkg::NUM_LINES,
    parameter int PIX_PER_LINE = led_lines_pkg::PIX_PER_LINE,
    parameter int FRAME_CYCLES = led_lines_pkg::FRAME_CYCLES,
    parameter int LATCH_CYCLES = led_lines_pkg::LATCH_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  SW,
    output logic                  MEM_RD_EN,
    output logic [7:0]            MEM_ADDR,
    input  logic [DATA_WIDTH-1:0] MEM_RD_DATA,
    input  logic [NUM_LINES-1:0]  LINE_REQ,
    output logic [NUM_LINES-1:0]  LINE_VLD,
    output logic [DATA_WIDTH-1:0] LINE_DATA,
    output logic [NUM_LINES-1:0]  LINE_LATCH,
    output logic                  FRAME_START,
    output logic                  OVERRUN,
    output logic                  BUSY
);

    import led_lines_pkg::*;

    localparam int c_FC_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int c_LC_W = $clog2(LATCH_CYCLES + 1);

    localparam logic [c_FC_W-1:0]    c_FRAME_LAST = c_FC_W'(FRAME_CYCLES - 1);
    localparam logic [c_LC_W-1:0]    c_LATCH_LAST = c_LC_W'(LATCH_CYCLES - 1);
    localparam logic [PIX_CNT_W-1:0] c_PIX_FULL   = PIX_CNT_W'(PIX_PER_LINE);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic                  r_sw_meta;
    logic                  r_sw_s;

    logic [c_FC_W-1:0]     r_frame_cnt;
    logic                  w_tick;
    logic                  r_frame_pend;
    logic                  r_overrun;

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic                  w_start;
    logic [c_LC_W-1:0]     r_latch_cnt;

    logic [PIX_CNT_W-1:0]  r_pix_cnt [NUM_LINES];
    logic                  w_all_full;
    logic [LINE_IDX_W-1:0] r_rr_ptr;

    logic [NUM_LINES-1:0]  w_elig;
    logic [NUM_LINES-1:0]  w_grant;
    logic                  w_grant_any;
    logic [LINE_IDX_W-1:0] w_grant_idx;

    logic                  r_rd_en;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic [NUM_LINES-1:0]  r_rd_line;

    logic [NUM_LINES-1:0]  r_vld;
    logic [DATA_WIDTH-1:0] r_data_hold;
    logic                  r_frame_start;

    // ------------------------------------------------------------------
    // Run-enable synchronizer
    // ------------------------------------------------------------------
    // Two-flop synchronizer for the asynchronous run switch
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sw_meta <= 1'b0;
            r_sw_s    <= 1'b0;
        end else begin
            r_sw_meta <= SW;
            r_sw_s    <= r_sw_meta;
        end
    end

    // ------------------------------------------------------------------
    // Frame timing
    // ------------------------------------------------------------------
    assign w_tick = (r_frame_cnt == c_FRAME_LAST);

    // Free-running frame period counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_frame_cnt <= '0;
        end else if (w_tick) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    // Pending-frame flag; a tick arriving while one is still pending is reported as overrun
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_frame_pend <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if ((r_state == ST_IDLE) && !r_sw_s) begin
                // Paused: nothing accumulates, so no overrun is reported
                r_frame_pend <= 1'b0;
            end else if (w_tick) begin
                r_frame_pend <= 1'b1;
                if (r_frame_pend && !w_start) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_start) begin
                r_frame_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scheduler FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; FETCH ends once every line is full and no read is awaiting its data
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_frame_pend && r_sw_s) begin
                    w_state_nxt = ST_FETCH;
                    w_start     = 1'b1;
                end
            end
            ST_FETCH: begin
                if (w_all_full && !r_rd_en) begin
                    w_state_nxt = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (r_latch_cnt == c_LATCH_LAST) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch period counter, only runs while in LATCH
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_latch_cnt <= '0;
        end else if (r_state == ST_LATCH) begin
            r_latch_cnt <= r_latch_cnt + 1'b1;
        end else begin
            r_latch_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Eligibility and arbitration
    // ------------------------------------------------------------------
    // A line may be served when it asks, is not yet full and has no read outstanding
    always_comb begin
        w_elig     = '0;
        w_all_full = 1'b1;
        for (int i = 0; i < NUM_LINES; i++) begin
            w_elig[i] = (r_state == ST_FETCH) && LINE_REQ[i] &&
                        (r_pix_cnt[i] < c_PIX_FULL) && !r_rd_line[i];
            if (r_pix_cnt[i] != c_PIX_FULL) begin
                w_all_full = 1'b0;
            end
        end
    end

    led_rr_arbiter #(
        .N     (NUM_LINES),
        .IDX_W (LINE_IDX_W)
    ) u_rr_arbiter (
        .i_elig  (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant)
    );

    // One-hot grant to binary line index
    always_comb begin
        w_grant_idx = '0;
        w_grant_any = |w_grant;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = LINE_IDX_W'(i);
            end
        end
    end

    // Per-line pixel counters (cleared at frame start) and round-robin pointer
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_pix_cnt[i] <= '0;
            end
            r_rr_ptr <= '0;
        end else if (w_start) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_pix_cnt[i] <= '0;
            end
        end else if (w_grant_any) begin
            r_pix_cnt[w_grant_idx] <= r_pix_cnt[w_grant_idx] + 1'b1;
            r_rr_ptr <= (int'(w_grant_idx) == NUM_LINES - 1) ? '0 : (w_grant_idx + 1'b1);
        end
    end

    // ------------------------------------------------------------------
    // Frame-buffer read and data return
    // ------------------------------------------------------------------
    // Issue the granted read; r_rd_line remembers which line the data belongs to
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_rd_line <= '0;
        end else begin
            r_rd_en   <= w_grant_any;
            r_rd_line <= w_grant;
            if (w_grant_any) begin
                r_rd_addr <= {w_grant_idx, r_pix_cnt[w_grant_idx][PIX_IDX_W-1:0]};
            end
        end
    end

    // Strobe the owning line while its data is on the bus and remember that word
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_vld       <= '0;
            r_data_hold <= '0;
        end else begin
            r_vld <= r_rd_line;
            if (|r_vld) begin
                r_data_hold <= MEM_RD_DATA;
            end
        end
    end

    // Frame-start pulse coincides with the first FETCH cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_start;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign MEM_RD_EN   = r_rd_en;
    assign MEM_ADDR    = r_rd_addr;
    assign LINE_VLD    = r_vld;
    // Memory data is only valid in the return cycle, so it is passed straight through then
    assign LINE_DATA   = (|r_vld) ? MEM_RD_DATA : r_data_hold;
    assign LINE_LATCH  = {NUM_LINES{r_state == ST_LATCH}};
    assign FRAME_START = r_frame_start;
    assign OVERRUN     = r_overrun;
    assign BUSY        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_led_line_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_line_sched
// Description : Scoreboard bench for led_line_sched with a small frame
//               geometry (4 pixels/line, 200-cycle frame, 20-cycle latch).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_line_sched;

    localparam int DW  = 25;
    localparam int NL  = 4;
    localparam int PPL = 4;
    localparam int FC  = 200;
    localparam int LC  = 20;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          SW = 1'b0;
    logic          MEM_RD_EN;
    logic [7:0]    MEM_ADDR;
    logic [DW-1:0] MEM_RD_DATA;
    logic [NL-1:0] LINE_REQ = '0;
    logic [NL-1:0] LINE_VLD;
    logic [DW-1:0] LINE_DATA;
    logic [NL-1:0] LINE_LATCH;
    logic          FRAME_START;
    logic          OVERRUN;
    logic          BUSY;

    led_line_sched #(
        .DATA_WIDTH   (DW),
        .NUM_LINES    (NL),
        .PIX_PER_LINE (PPL),
        .FRAME_CYCLES (FC),
        .LATCH_CYCLES (LC)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .SW          (SW),
        .MEM_RD_EN   (MEM_RD_EN),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_RD_DATA (MEM_RD_DATA),
        .LINE_REQ    (LINE_REQ),
        .LINE_VLD    (LINE_VLD),
        .LINE_DATA   (LINE_DATA),
        .LINE_LATCH  (LINE_LATCH),
        .FRAME_START (FRAME_START),
        .OVERRUN     (OVERRUN),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    // Frame-buffer contents are a fixed function of the address
    function automatic logic [DW-1:0] mem_f(input logic [7:0] a);
        mem_f = {1'b1, a ^ 8'hC3, 8'h3C, a};
    endfunction

    function automatic logic [NL-1:0] onehot(input logic [7:0] a);
        onehot = 4'b0001 << a[7:6];
    endfunction

    // Synchronous-read memory: data valid the cycle after the strobe, junk otherwise
    logic [DW-1:0] mem_q = '0;
    always @(posedge CLK) begin
        if (MEM_RD_EN) mem_q <= mem_f(MEM_ADDR);
        else           mem_q <= 25'h1A5A5A5;
    end
    assign MEM_RD_DATA = mem_q;

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    logic [7:0] rd_q[$];
    logic [7:0] vld_q[$];
    int         rd_cyc[$];
    int         ovr_cyc[$];

    int rd_cnt = 0, fs_cnt = 0, latch_done = 0, ovr_cnt = 0, busy_low = 0, cyc = 0;
    int latch_run = 0;
    bit prev_rd = 0, prev_vld = 0;
    logic [7:0]    prev_addr = '0;
    logic [7:0]    mon_a;
    logic [DW-1:0] last_data = '0;

    task automatic chk_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int get_cnt(input int sel);
        case (sel)
            0:       get_cnt = rd_cnt;
            1:       get_cnt = fs_cnt;
            default: get_cnt = latch_done;
        endcase
    endfunction

    task automatic wait_ge(input string nm, input int sel, input int target, input int limit);
        int k = 0;
        while (get_cnt(sel) < target && k < limit) begin
            @(negedge CLK);
            k++;
        end
        chk_eq(nm, 64'(get_cnt(sel) >= target), 64'd1);
    endtask

    task automatic push_exp(input logic [7:0] a);
        rd_q.push_back(a);
        vld_q.push_back(a);
    endtask

    task automatic push_full_frame();
        logic [1:0] lb;
        logic [5:0] pb;
        for (int p = 0; p < PPL; p++) begin
            for (int l = 0; l < NL; l++) begin
                lb = 2'(l);
                pb = 6'(p);
                push_exp({lb, pb});
            end
        end
    endtask

    // Assert reset away from the clock edge, check outputs drop at once, flush expectations
    task automatic apply_reset(input string nm);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk_eq(nm, 64'({MEM_RD_EN, MEM_ADDR, LINE_VLD, LINE_DATA, LINE_LATCH,
                         FRAME_START, OVERRUN, BUSY}), 64'd0);
        rd_q.delete();
        vld_q.delete();
        rd_cyc.delete();
        ovr_cyc.delete();
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops expectations whenever the DUT presents a read or data
    // ------------------------------------------------------------------
    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_rd   = 1'b0;
            prev_vld  = 1'b0;
            latch_run = 0;
        end else begin
            cyc++;
            if (LINE_VLD != '0) begin
                chk_eq("vld_timing", 64'(LINE_VLD), prev_rd ? 64'(onehot(prev_addr)) : 64'd0);
                if (vld_q.size() == 0) begin
                    chk_eq("vld_unexpected", 64'(LINE_VLD), 64'd0);
                end else begin
                    mon_a = vld_q.pop_front();
                    chk_eq("vld_line", 64'(LINE_VLD), 64'(onehot(mon_a)));
                    chk_eq("vld_data", 64'(LINE_DATA), 64'(mem_f(mon_a)));
                end
                last_data = LINE_DATA;
            end else if (prev_vld) begin
                chk_eq("data_hold", 64'(LINE_DATA), 64'(last_data));
            end
            prev_vld = (LINE_VLD != '0);

            if (MEM_RD_EN) begin
                rd_cnt++;
                rd_cyc.push_back(cyc);
                if (rd_q.size() == 0) begin
                    chk_eq("rd_unexpected", 64'(MEM_RD_EN), 64'd0);
                end else begin
                    mon_a = rd_q.pop_front();
                    chk_eq("rd_addr", 64'(MEM_ADDR), 64'(mon_a));
                end
            end
            prev_rd   = MEM_RD_EN;
            prev_addr = MEM_ADDR;

            if (FRAME_START) fs_cnt++;
            if (OVERRUN) begin
                ovr_cnt++;
                ovr_cyc.push_back(cyc);
            end
            if (!BUSY) busy_low++;

            if (LINE_LATCH == '1) begin
                latch_run++;
            end else if (latch_run != 0) begin
                chk_eq("latch_len", 64'(latch_run), 64'(LC));
                latch_done++;
                latch_run = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int b_fs, b_ld, b_rd, b_ovr, b_busy;
    logic [7:0] c2_tab [16] = '{8'h80, 8'h81, 8'h82, 8'h83,
                                8'hC0, 8'h00, 8'h40, 8'hC1, 8'h01, 8'h41,
                                8'hC2, 8'h02, 8'h42, 8'hC3, 8'h03, 8'h43};

    initial begin
        // Case 1: every line requesting, full frame in round-robin order
        apply_reset("reset_state");
        LINE_REQ = 4'hF;
        SW = 1'b1;
        push_full_frame();
        b_fs = fs_cnt;
        b_ld = latch_done;
        wait_ge("c1_frame_start", 1, b_fs + 1, 400);
        wait_ge("c1_latch_done", 2, b_ld + 1, 200);
        chk_eq("c1_rd_left", 64'(rd_q.size()), 64'd0);
        chk_eq("c1_vld_left", 64'(vld_q.size()), 64'd0);
        chk_eq("c1_fs_count", 64'(fs_cnt - b_fs), 64'd1);
        chk_eq("c1_idle_after", 64'(BUSY), 64'd0);

        // Case 2: only line 2 asks at first, the rest join later
        apply_reset("c2_reset");
        LINE_REQ = 4'b0100;
        SW = 1'b1;
        for (int i = 0; i < 16; i++) push_exp(c2_tab[i]);
        b_fs = fs_cnt;
        b_ld = latch_done;
        wait_ge("c2_frame_start", 1, b_fs + 1, 400);
        repeat (10) @(negedge CLK);
        LINE_REQ = 4'hF;
        wait_ge("c2_latch_done", 2, b_ld + 1, 200);
        chk_eq("c2_rd_left", 64'(rd_q.size()), 64'd0);
        chk_eq("c2_vld_left", 64'(vld_q.size()), 64'd0);
        chk_eq("c2_rd_count", 64'(rd_cyc.size()), 64'd16);
        if (rd_cyc.size() >= 4) begin
            for (int k = 0; k < 3; k++) begin
                chk_eq("c2_line2_gap", 64'(rd_cyc[k + 1] - rd_cyc[k]), 64'd2);
            end
        end

        // Case 3: line 3 never asks, FETCH stalls and later ticks overrun
        apply_reset("c3_reset");
        LINE_REQ = 4'b0111;
        SW = 1'b1;
        for (int p = 0; p < PPL; p++) begin
            push_exp(8'h00 + 8'(p));
            push_exp(8'h40 + 8'(p));
            push_exp(8'h80 + 8'(p));
        end
        b_fs = fs_cnt;
        wait_ge("c3_frame_start", 1, b_fs + 1, 400);
        b_busy = busy_low;
        b_ovr  = ovr_cnt;
        repeat (700) @(negedge CLK);
        chk_eq("c3_rd_left", 64'(rd_q.size()), 64'd0);
        chk_eq("c3_vld_left", 64'(vld_q.size()), 64'd0);
        chk_eq("c3_busy_low", 64'(busy_low - b_busy), 64'd0);
        chk_eq("c3_busy_now", 64'(BUSY), 64'd1);
        chk_eq("c3_overruns", 64'(ovr_cnt - b_ovr), 64'd2);
        if (ovr_cyc.size() >= 2) begin
            chk_eq("c3_overrun_period", 64'(ovr_cyc[1] - ovr_cyc[0]), 64'(FC));
        end
        chk_eq("c3_fs_count", 64'(fs_cnt - b_fs), 64'd1);

        // Case 4: switch released mid-frame; frame finishes, then stays idle
        apply_reset("c4_reset");
        LINE_REQ = 4'hF;
        SW = 1'b1;
        push_full_frame();
        b_fs  = fs_cnt;
        b_ld  = latch_done;
        b_rd  = rd_cnt;
        b_ovr = ovr_cnt;
        wait_ge("c4_fifth_grant", 0, b_rd + 5, 400);
        SW = 1'b0;
        wait_ge("c4_latch_done", 2, b_ld + 1, 200);
        repeat (450) @(negedge CLK);
        chk_eq("c4_rd_left", 64'(rd_q.size()), 64'd0);
        chk_eq("c4_vld_left", 64'(vld_q.size()), 64'd0);
        chk_eq("c4_fs_count", 64'(fs_cnt - b_fs), 64'd1);
        chk_eq("c4_overruns", 64'(ovr_cnt - b_ovr), 64'd0);
        chk_eq("c4_idle", 64'(BUSY), 64'd0);

        // Case 5: reset in the middle of FETCH, then a clean restart
        apply_reset("c5_reset");
        LINE_REQ = 4'hF;
        SW = 1'b1;
        push_full_frame();
        b_rd = rd_cnt;
        wait_ge("c5_sixth_grant", 0, b_rd + 6, 400);
        apply_reset("c5_reset_midframe");
        push_full_frame();
        b_fs = fs_cnt;
        b_ld = latch_done;
        wait_ge("c5_restart", 1, b_fs + 1, 400);
        wait_ge("c5_latch_done", 2, b_ld + 1, 200);
        chk_eq("c5_rd_left", 64'(rd_q.size()), 64'd0);
        chk_eq("c5_vld_left", 64'(vld_q.size()), 64'd0);
        chk_eq("c5_fs_count", 64'(fs_cnt - b_fs), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
